// File: rtl/regfile_sb_pkg.sv
// Shared defaults and read-source decode for regfile_sb.
// Imported by the scoreboard and top-level register file.
package regfile_sb_pkg;

  localparam int DW_DEF    = 32;
  localparam int AW_DEF    = 5;
  localparam int NREAD_DEF = 2;

  // Where a read port takes its data from this cycle.
  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_WD1,
    SRC_WD0,
    SRC_MEM
  } rsrc_e;

  // Hardwired zero beats forwarding; late writeback beats ALU
  // writeback, matching the storage priority on a collision.
  function automatic rsrc_e rsrc_sel(
    input logic zero,
    input logic hit1,
    input logic hit0
  );
    if (zero) return SRC_ZERO;
    if (hit1) return SRC_WD1;
    if (hit0) return SRC_WD0;
    return SRC_MEM;
  endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Busy scoreboard: one pending-late-write flag per register.
// Ports: clk, reset_n, bset/bset_a (mark busy), we1/wa1 (clear), busy (flags).
module regfile_sb_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              bset,
  input  logic [AW-1:0]     bset_a,
  input  logic              we1,
  input  logic [AW-1:0]     wa1,
  output logic [2**AW-1:0]  busy
);

  localparam int DEPTH = 2**AW;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Set is applied after clear so a new producer issued in the
  // same cycle as the old one retires keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (we1) busy_d[wa1] = 1'b0;
    if (bset) busy_d[bset_a] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read, dual-write register file with busy scoreboard.
// Ports: ra/ren -> rd/rbusy/stall reads; we0/wa0/wd0, we1/wa1/wd1 writes; bset/bset_a busy marking.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int NREAD    = NREAD_DEF,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NREAD*AW-1:0] ra,
  input  logic [NREAD-1:0]    ren,
  output logic [NREAD*DW-1:0] rd,
  output logic [NREAD-1:0]    rbusy,
  output logic                stall,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [DW-1:0]       wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [DW-1:0]       wd1,
  input  logic                bset,
  input  logic [AW-1:0]       bset_a
);

  localparam int DEPTH = 2**AW;

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             we0_v;
  logic             we1_v;

  // While reset is held the file must read as all-zero, so
  // in-flight writes are not forwarded either.
  assign we0_v = we0 & reset_n;
  assign we1_v = we1 & reset_n;

  regfile_sb_scoreboard #(
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk     (clk),
    .reset_n (reset_n),
    .bset    (bset),
    .bset_a  (bset_a),
    .we1     (we1),
    .wa1     (wa1),
    .busy    (busy)
  );

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    if ((ZERO_REG != 0) && (e == 0)) begin : g_zero
      assign mem[e] = '0;
    end else begin : g_reg
      logic          w0;
      logic          w1;
      logic [DW-1:0] q_q;
      logic [DW-1:0] q_d;

      assign w0 = we0 && (wa0 == AW'(e));
      assign w1 = we1 && (wa1 == AW'(e));

      always_comb begin
        q_d = q_q;
        if (w1) begin
          q_d = wd1;
        end else if (w0) begin
          q_d = wd0;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          q_q <= '0;
        end else begin
          q_q <= q_d;
        end
      end

      assign mem[e] = q_q;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic          z;
    logic          h1;
    logic          h0;
    rsrc_e         src;
    logic [DW-1:0] d;

    assign a  = ra[i*AW +: AW];
    assign z  = (ZERO_REG != 0) && (a == '0);
    assign h1 = (BYPASS != 0) && we1_v && (wa1 == a);
    assign h0 = (BYPASS != 0) && we0_v && (wa0 == a);
    assign src = rsrc_sel(z, h1, h0);

    always_comb begin
      d = '0;
      unique case (src)
        SRC_ZERO: d = '0;
        SRC_WD1:  d = wd1;
        SRC_WD0:  d = wd0;
        default:  d = mem[a];
      endcase
    end

    assign rd[i*DW +: DW] = d;
    // A late write landing this cycle resolves the hazard.
    assign rbusy[i] = busy[a] & ~h1 & ~z;
  end

  assign stall = |(ren & rbusy);

endmodule
